// File: rtl/updown_counter_hexdisp.sv
// Modulo-N up/down counter advanced by an internal prescaler tick, with its value
// shown as hex digits on time-multiplexed active-low 7-segment displays.
module updown_counter_hexdisp #(
  parameter int WIDTH      = 8,
  parameter int MODULO     = 256,
  parameter int DIV_TIMES  = 100000000,
  parameter int SCAN_TIMES = 100000
) (
  input  logic                       CLK,
  input  logic                       rst_n,
  input  logic                       iEn,
  input  logic                       iUp,
  input  logic                       iClr,
  input  logic                       iLoad,
  input  logic [WIDTH-1:0]           iLoadData,
  output logic [WIDTH-1:0]           oQ,
  output logic                       oCarry,
  output logic                       oTick,
  output logic [(WIDTH+3)/4-1:0]     oAn,
  output logic [6:0]                 oDisplay
);

  localparam int DIGITS = (WIDTH + 3) / 4;
  localparam int PAD_W  = DIGITS * 4;
  localparam int DIV_W  = (DIV_TIMES > 1) ? $clog2(DIV_TIMES) : 1;
  localparam int SCAN_W = (SCAN_TIMES > 1) ? $clog2(SCAN_TIMES) : 1;
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [WIDTH-1:0]  MAX_VAL  = WIDTH'(MODULO - 1);
  localparam logic [DIV_W-1:0]  DIV_MAX  = DIV_W'(DIV_TIMES - 1);
  localparam logic [SCAN_W-1:0] SCAN_MAX = SCAN_W'(SCAN_TIMES - 1);
  localparam logic [IDX_W-1:0]  IDX_MAX  = IDX_W'(DIGITS - 1);
  localparam logic [DIGITS-1:0] AN_RST   = ~DIGITS'(1);

  logic [DIV_W-1:0]  div_q, div_d;
  logic              tick_q, tick_d;
  logic [WIDTH-1:0]  q_q, q_d;
  logic              carry_q, carry_d;
  logic [SCAN_W-1:0] scan_q, scan_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DIGITS-1:0] an_q, an_d;

  logic              tick;
  logic              scan_wrap;
  logic [WIDTH-1:0]  load_val;
  logic [PAD_W-1:0]  q_pad;
  logic [3:0]        nibble;
  logic [6:0]        seg;

  assign tick = (div_q == DIV_MAX);

  // A clear restarts the prescaler and swallows the tick on that edge.
  always_comb begin
    div_d  = div_q;
    tick_d = tick & ~iClr;
    if (iClr) begin
      div_d = '0;
    end else if (tick) begin
      div_d = '0;
    end else begin
      div_d = div_q + DIV_W'(1);
    end
  end

  always_comb begin
    q_d      = q_q;
    carry_d  = 1'b0;
    load_val = (iLoadData > MAX_VAL) ? MAX_VAL : iLoadData;
    if (iClr) begin
      q_d = '0;
    end else if (iLoad) begin
      q_d = load_val;
    end else if (tick && iEn) begin
      if (iUp) begin
        if (q_q == MAX_VAL) begin
          q_d     = '0;
          carry_d = 1'b1;
        end else begin
          q_d = q_q + WIDTH'(1);
        end
      end else begin
        if (q_q == '0) begin
          q_d     = MAX_VAL;
          carry_d = 1'b1;
        end else begin
          q_d = q_q - WIDTH'(1);
        end
      end
    end
  end

  // Digit select is decoded from the next index so oAn always matches idx_q.
  always_comb begin
    scan_wrap = (scan_q == SCAN_MAX);
    scan_d    = scan_wrap ? '0 : scan_q + SCAN_W'(1);
    idx_d     = idx_q;
    if (scan_wrap) begin
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IDX_W'(1);
    end
    an_d = '1;
    for (int i = 0; i < DIGITS; i++) begin
      an_d[i] = (idx_d != IDX_W'(i));
    end
  end

  always_comb begin
    q_pad               = '0;
    q_pad[WIDTH-1:0]    = q_q;
    nibble              = 4'h0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        nibble = q_pad[i*4 +: 4];
      end
    end
  end

  always_comb begin
    seg = 7'b1111111;
    case (nibble)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'b1111111;
    endcase
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= '0;
      tick_q  <= 1'b0;
      q_q     <= '0;
      carry_q <= 1'b0;
      scan_q  <= '0;
      idx_q   <= '0;
      an_q    <= AN_RST;
    end else begin
      div_q   <= div_d;
      tick_q  <= tick_d;
      q_q     <= q_d;
      carry_q <= carry_d;
      scan_q  <= scan_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
    end
  end

  assign oQ       = q_q;
  assign oCarry   = carry_q;
  assign oTick    = tick_q;
  assign oAn      = an_q;
  assign oDisplay = seg;

endmodule

// File: tb/tb_updown_counter_hexdisp.sv
// Directed bench for updown_counter_hexdisp: a small decimal counter (WIDTH=4, MODULO=10,
// DIV_TIMES=4) and a full-range byte counter (WIDTH=8, DIV_TIMES=1) share one clock and reset.
module tb_updown_counter_hexdisp;

  logic       CLK;
  logic       rst_n;

  logic       aEn, aUp, aClr, aLoad;
  logic [3:0] aData;
  logic [3:0] aQ;
  logic       aCarry, aTick;
  logic [0:0] aAn;
  logic [6:0] aDisp;

  logic       bEn, bUp, bClr, bLoad;
  logic [7:0] bData;
  logic [7:0] bQ;
  logic       bCarry, bTick;
  logic [1:0] bAn;
  logic [6:0] bDisp;

  int checkCount = 0;
  int passCount  = 0;
  int edgeCount  = 0;

  updown_counter_hexdisp #(
    .WIDTH(4), .MODULO(10), .DIV_TIMES(4), .SCAN_TIMES(2)
  ) dutA (
    .CLK(CLK), .rst_n(rst_n), .iEn(aEn), .iUp(aUp), .iClr(aClr), .iLoad(aLoad),
    .iLoadData(aData), .oQ(aQ), .oCarry(aCarry), .oTick(aTick), .oAn(aAn),
    .oDisplay(aDisp)
  );

  updown_counter_hexdisp #(
    .WIDTH(8), .MODULO(256), .DIV_TIMES(1), .SCAN_TIMES(2)
  ) dutB (
    .CLK(CLK), .rst_n(rst_n), .iEn(bEn), .iUp(bUp), .iClr(bClr), .iLoad(bLoad),
    .iLoadData(bData), .oQ(bQ), .oCarry(bCarry), .oTick(bTick), .oAn(bAn),
    .oDisplay(bDisp)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference segment patterns, active-low {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hexFont(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Advance one clock edge and land 1 time unit after it, away from the edge.
  task automatic step();
    @(posedge CLK);
    #1;
    edgeCount++;
  endtask

  task automatic applyStimulus(input logic en, input logic up, input logic clr,
                               input logic load, input logic [3:0] data);
    aEn = en; aUp = up; aClr = clr; aLoad = load; aData = data;
  endtask

  task automatic applyStimulusB(input logic en, input logic up, input logic clr,
                                input logic load, input logic [7:0] data);
    bEn = en; bUp = up; bClr = clr; bLoad = load; bData = data;
  endtask

  task automatic checkA(input string tag, input int expQ, input logic expCarry,
                        input logic expTick);
    checkOutput({tag, "/q"},     32'(aQ),     32'(expQ));
    checkOutput({tag, "/carry"}, 32'(aCarry), 32'(expCarry));
    checkOutput({tag, "/tick"},  32'(aTick),  32'(expTick));
    checkOutput({tag, "/an"},    32'(aAn),    32'd0);
    checkOutput({tag, "/disp"},  32'(aDisp),  32'(hexFont(4'(expQ))));
  endtask

  // With SCAN_TIMES=2 the byte counter's digit index flips every two edges.
  task automatic checkB(input string tag, input logic [7:0] expQ, input logic expCarry,
                        input logic expTick);
    logic       idx;
    logic [1:0] expAn;
    logic [3:0] nib;
    idx   = ((edgeCount / 2) % 2) == 1;
    expAn = idx ? 2'b01 : 2'b10;
    nib   = idx ? expQ[7:4] : expQ[3:0];
    checkOutput({tag, "/q"},     32'(bQ),     32'(expQ));
    checkOutput({tag, "/carry"}, 32'(bCarry), 32'(expCarry));
    checkOutput({tag, "/tick"},  32'(bTick),  32'(expTick));
    checkOutput({tag, "/an"},    32'(bAn),    32'(expAn));
    checkOutput({tag, "/disp"},  32'(bDisp),  32'(hexFont(nib)));
  endtask

  initial begin
    logic [7:0] holdVals [4];
    holdVals = '{8'hAB, 8'hCD, 8'h37, 8'hF2};

    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    applyStimulusB(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    #1 rst_n = 1'b0;
    #2;
    edgeCount = 0;
    checkA("resetA", 0, 1'b0, 1'b0);
    checkB("resetB", 8'h00, 1'b0, 1'b0);

    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
    #4 rst_n = 1'b1;
    edgeCount = 0;

    for (int n = 1; n <= 44; n++) begin
      step();
      checkA("countUp", (n / 4) % 10, n == 40, (n % 4) == 0);
    end

    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
    for (int n = 0; n < 3; n++) begin
      step();
      checkA("holdBeforeClr", 1, 1'b0, 1'b0);
    end

    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
    step();
    checkA("clrOnTick", 0, 1'b0, 1'b0);

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    for (int m = 1; m <= 8; m++) begin
      step();
      checkA("countDown", (m < 4) ? 0 : ((m < 8) ? 9 : 8), m == 4, (m % 4) == 0);
    end

    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
    for (int m = 9; m <= 11; m++) begin
      step();
      checkA("upToggleOffTick", 8, 1'b0, 1'b0);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    step();
    checkA("downAfterToggle", 7, 1'b0, 1'b1);

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'd12);
    step();
    checkA("loadClamp", 9, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'd5);
    step();
    checkA("loadInRange", 5, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    step();
    checkA("holdAfterLoad", 5, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    step();
    checkA("prescalerKept", 6, 1'b0, 1'b1);

    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 4'd7);
    step();
    checkA("clrBeatsLoad", 0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    for (int k = 1; k <= 7; k++) begin
      step();
      checkA("restartAfterClr", (k < 4) ? 0 : 1, 1'b0, k == 4);
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 4'd3);
    step();
    checkA("loadOnTick", 3, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    for (int k = 9; k <= 16; k++) begin
      step();
      checkA("countToFive", (k < 12) ? 3 : ((k < 16) ? 4 : 5), 1'b0, (k % 4) == 0);
    end

    #2 rst_n = 1'b0;
    edgeCount = 0;
    #1;
    checkA("asyncResetA", 0, 1'b0, 1'b0);
    checkB("asyncResetB", 8'h00, 1'b0, 1'b0);
    #1 rst_n = 1'b1;

    for (int e = 1; e <= 4; e++) begin
      step();
      checkA("afterRelease", (e < 4) ? 0 : 1, 1'b0, e == 4);
    end

    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    for (int e = 5; e <= 24; e++) begin
      step();
      checkA("enableLow", 1, 1'b0, (e % 4) == 0);
    end

    applyStimulusB(1'b1, 1'b1, 1'b0, 1'b1, 8'hFE);
    step();
    checkB("loadFE", 8'hFE, 1'b0, 1'b1);
    applyStimulusB(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    step();
    checkB("upFF", 8'hFF, 1'b0, 1'b1);
    step();
    checkB("wrapUp", 8'h00, 1'b1, 1'b1);
    step();
    checkB("up01", 8'h01, 1'b0, 1'b1);

    applyStimulusB(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
    step();
    checkB("load00", 8'h00, 1'b0, 1'b1);
    applyStimulusB(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    step();
    checkB("wrapDown", 8'hFF, 1'b1, 1'b1);
    step();
    checkB("downFE", 8'hFE, 1'b0, 1'b1);

    for (int v = 0; v < 4; v++) begin
      applyStimulusB(1'b0, 1'b1, 1'b0, 1'b1, holdVals[v]);
      step();
      checkB("loadHold", holdVals[v], 1'b0, 1'b1);
      applyStimulusB(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      for (int h = 0; h < 3; h++) begin
        step();
        checkB("scanHold", holdVals[v], 1'b0, 1'b1);
      end
    end

    applyStimulusB(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    step();
    checkB("clrB", 8'h00, 1'b0, 1'b0);
    applyStimulusB(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    step();
    checkB("afterClrB", 8'h01, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
